// File: rtl/card_row_renderer_pkg.sv
// rtl/card_row_renderer_pkg.sv - shared colours, slot entry and pipeline flag types
package card_row_renderer_pkg;

   localparam int          CARD_W_MAX = 8;
   localparam logic [11:0] KEY_DEF    = 12'hF0F;
   localparam logic [11:0] BG_DEF     = 12'h000;
   localparam logic [11:0] HL_DEF     = 12'hFF0;

   typedef struct packed {
      logic                  present;
      logic [CARD_W_MAX-1:0] card;
   } slot_entry_t;

   typedef struct packed {
      logic vld;
      logic show;
      logic hl;
   } pix_flags_t;

endpackage

// File: rtl/card_hand_buffer.sv
// rtl/card_hand_buffer.sv - shadow/active hand registers with frame-start swap and selection latch
module card_hand_buffer
   import card_row_renderer_pkg::*;
#(
   parameter int SLOTS  = 10,
   parameter int CARD_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              wr_en,
   input  logic [3:0]        wr_slot,
   input  logic [CARD_W-1:0] wr_card,
   input  logic              wr_present,
   input  logic              clr_hand,
   input  logic [3:0]        sel_slot,
   input  logic [3:0]        rd_slot,
   output slot_entry_t       rd_entry,
   output logic              rd_sel
);

   slot_entry_t shadow_q [SLOTS];
   slot_entry_t active_q [SLOTS];
   logic [3:0]  sel_q;
   logic        sel_vld_q;
   logic        wr_ok;
   logic        sel_ok;

   assign wr_ok  = wr_en && (int'(wr_slot) < SLOTS);
   assign sel_ok = int'(sel_slot) < SLOTS;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         sel_q     <= '0;
         sel_vld_q <= 1'b0;
      end else begin
         if (frame_start) begin
            for (int i = 0; i < SLOTS; i++) active_q[i] <= shadow_q[i];
            sel_q     <= sel_slot;
            sel_vld_q <= sel_ok;
         end
         // later assignment wins, so a write in the same cycle as a clear survives
         for (int i = 0; i < SLOTS; i++) begin
            if (clr_hand) shadow_q[i].present <= 1'b0;
            if (wr_ok && wr_slot == 4'(i)) begin
               shadow_q[i].present <= wr_present;
               shadow_q[i].card    <= CARD_W_MAX'(wr_card);
            end
         end
      end
   end

   // On the frame-start cycle the pixel already belongs to the new frame.
   always_comb begin
      rd_entry = '0;
      rd_sel   = 1'b0;
      if (int'(rd_slot) < SLOTS) begin
         rd_entry = frame_start ? shadow_q[rd_slot] : active_q[rd_slot];
         rd_sel   = frame_start ? (sel_ok && sel_slot == rd_slot)
                                : (sel_vld_q && sel_q == rd_slot);
      end
   end

endmodule

// File: rtl/card_row_renderer.sv
// rtl/card_row_renderer.sv - renders one row of card sprites from a block ROM onto the VGA scan
module card_row_renderer
   import card_row_renderer_pkg::*;
#(
   parameter int          SLOTS   = 10,
   parameter int          TILE_W  = 32,
   parameter int          TILE_H  = 46,
   parameter int          ROW_X0  = 0,
   parameter int          ROW_Y0  = 0,
   parameter int          CARD_W  = 6,
   parameter int          ADDR_W  = 15,
   parameter int          ROM_LAT = 1,
   parameter logic [11:0] KEY     = KEY_DEF,
   parameter logic [11:0] BG      = BG_DEF,
   parameter logic [11:0] HL      = HL_DEF,
   parameter int          BLINK   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        h_cnt,
   input  logic [9:0]        v_cnt,
   input  logic              valid,
   input  logic              wr_en,
   input  logic [3:0]        wr_slot,
   input  logic [CARD_W-1:0] wr_card,
   input  logic              wr_present,
   input  logic              clr_hand,
   input  logic [3:0]        sel_slot,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic [11:0]       pixel,
   output logic              pixel_valid
);

   localparam int PX_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int PY_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int BL_W = $clog2(BLINK) + 1;

   logic              frame_start;
   logic              in_tile;
   logic [PX_W-1:0]   px_cur, col_px_d, col_px_q;
   logic [3:0]        slot_cur, col_slot_d, col_slot_q;
   logic [PY_W-1:0]   py;
   logic              border;
   slot_entry_t       ent;
   logic              ent_sel;
   logic [BL_W-1:0]   blink_cnt_d, blink_cnt_q;
   logic              blink_wrap, phase_d, phase_q, phase_now;
   pix_flags_t        a_d, a_q, tail;
   pix_flags_t        dl_q [ROM_LAT];
   logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
   logic [11:0]       pixel_d, pixel_q;
   logic              pixel_valid_q;

   assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
   assign in_tile     = valid
                        && int'(h_cnt) >= ROW_X0 && int'(h_cnt) < ROW_X0 + SLOTS * TILE_W
                        && int'(v_cnt) >= ROW_Y0 && int'(v_cnt) < ROW_Y0 + TILE_H;
   assign py          = PY_W'(int'(v_cnt) - ROW_Y0);

   // Column counters restart on the row's first column and carry px into slot.
   always_comb begin
      px_cur   = col_px_q;
      slot_cur = col_slot_q;
      if (h_cnt == 10'(ROW_X0)) begin
         px_cur   = '0;
         slot_cur = '0;
      end
      col_px_d   = px_cur + 1'b1;
      col_slot_d = slot_cur;
      if (px_cur == PX_W'(TILE_W - 1)) begin
         col_px_d   = '0;
         col_slot_d = slot_cur + 1'b1;
      end
   end

   assign blink_wrap  = (blink_cnt_q == BL_W'(BLINK - 1));
   assign blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
   assign phase_d     = blink_wrap ? ~phase_q : phase_q;
   assign phase_now   = frame_start ? phase_d : phase_q;

   card_hand_buffer #(
      .SLOTS  (SLOTS),
      .CARD_W (CARD_W)
   ) u_hand (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .wr_en       (wr_en),
      .wr_slot     (wr_slot),
      .wr_card     (wr_card),
      .wr_present  (wr_present),
      .clr_hand    (clr_hand),
      .sel_slot    (sel_slot),
      .rd_slot     (slot_cur),
      .rd_entry    (ent),
      .rd_sel      (ent_sel)
   );

   assign border = (px_cur == '0) || (px_cur == PX_W'(TILE_W - 1))
                || (py == '0) || (py == PY_W'(TILE_H - 1));

   always_comb begin
      a_d.vld    = valid;
      a_d.show   = in_tile && ent.present;
      a_d.hl     = in_tile && ent.present && ent_sel && phase_now && border;
      rom_addr_d = rom_addr_q;
      if (in_tile)
         rom_addr_d = ADDR_W'(32'(ent.card) * 32'(TILE_W * TILE_H)
                              + 32'(py) * 32'(TILE_W) + 32'(px_cur));
   end

   assign tail = dl_q[ROM_LAT-1];

   always_comb begin
      pixel_d = rom_data;
      if (!tail.vld)             pixel_d = 12'h000;
      else if (!tail.show)       pixel_d = BG;
      else if (tail.hl)          pixel_d = HL;
      else if (rom_data == KEY)  pixel_d = BG;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_px_q      <= '0;
         col_slot_q    <= '0;
         blink_cnt_q   <= '0;
         phase_q       <= 1'b0;
         a_q           <= '0;
         for (int k = 0; k < ROM_LAT; k++) dl_q[k] <= '0;
         rom_addr_q    <= '0;
         pixel_q       <= '0;
         pixel_valid_q <= 1'b0;
      end else begin
         col_px_q   <= col_px_d;
         col_slot_q <= col_slot_d;
         if (frame_start) begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
         end
         a_q     <= a_d;
         dl_q[0] <= a_q;
         for (int k = 1; k < ROM_LAT; k++) dl_q[k] <= dl_q[k-1];
         rom_addr_q    <= rom_addr_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= tail.vld;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign pixel       = pixel_q;
   assign pixel_valid = pixel_valid_q;

endmodule

// File: doc/card_row_renderer.md
# card_row_renderer

Parametrised renderer for one horizontal row of card sprites. It sits between `vga_controller` and a card-sprite block ROM. It maps the incoming scan position onto `SLOTS` card slots and issues ROM addresses for each slot's card. It delay-aligns the returned pixel with its scan flags and outputs a final 12-bit RGB pixel with colour-key transparency, empty-slot background and a blinking highlight border on the selected slot. Hand contents are double-buffered and swap only at frame start, so the displayed row never tears.

## Interface
- `SLOTS`, 10: number of card slots in the row (1..16).
- `TILE_W`, 32: sprite width in pixels.
- `TILE_H`, 46: sprite height in pixels.
- `ROW_X0`, 0: first h_cnt column of slot 0.
- `ROW_Y0`, 0: first v_cnt line of the row.
- `CARD_W`, 6: card-index width; the ROM holds 2^CARD_W sprites back to back.
- `ADDR_W`, 15: ROM address width.
- `ROM_LAT`, 1: ROM read latency in clk cycles (1..3).
- `KEY`, 12'hF0F: transparent colour key.
- `BG`, 12'h000: background colour.
- `HL`, 12'hFF0: highlight border colour.
- `BLINK`, 16: highlight half-period in frames.

Ports:
- `clk` in 1: pixel clock (25 MHz).
- `rst` in 1: asynchronous, active-low reset.
- `h_cnt` in 10: scan column from `vga_controller`.
- `v_cnt` in 10: scan line from `vga_controller`.
- `valid` in 1: active-video flag.
- `wr_en` in 1: write one slot of the shadow hand.
- `wr_slot` in 4: slot to write.
- `wr_card` in CARD_W: card index to write.
- `wr_present` in 1: present bit to write.
- `clr_hand` in 1: clear all shadow present bits.
- `sel_slot` in 4: slot to highlight; any value ≥ SLOTS means no highlight.
- `rom_addr` out ADDR_W: sprite ROM address.
- `rom_data` in 12: ROM read data.
- `pixel` out 12: final RGB pixel.
- `pixel_valid` out 1: `valid` delayed to align with `pixel`.

## Operation
- **Frame start:** cycle where `h_cnt==0 && v_cnt==0`.
  - At frame start the shadow hand (card + present per slot) is copied into the active hand.
  - `sel_slot` is latched into `sel_q`.
  - The blink counter advances; the phase toggles every `BLINK` frames.
- **Shadow writes:**
  - `wr_en` with `wr_slot ≥ SLOTS` is ignored.
  - `clr_hand` and `wr_en` in the same cycle: clear first, then write, so the written slot ends with `wr_present`.
  - A write on the frame-start cycle lands in the shadow and appears in the next frame, not the current one.
- **Geometry:**
  - dx = h_cnt−ROW_X0, dy = v_cnt−ROW_Y0.
  - in_tile = valid && h_cnt ≥ ROW_X0 && dx < SLOTS·TILE_W && v_cnt ≥ ROW_Y0 && dy < TILE_H.
  - slot = dx / TILE_W, px = dx % TILE_W, py = dy.
  - TILE_W is not required to be a power of two. Use column counters (px wraps at TILE_W−1, slot increments), not dividers.
- **Address:** rom_addr = card·TILE_W·TILE_H + py·TILE_W + px, truncated to ADDR_W. Outside the tile, rom_addr holds its previous value.
- **Pixel select, in priority order:**
  1. !valid → 0.
  2. !in_tile, or slot not present → BG.
  3. Border of the `sel_q` slot while the blink phase is on → HL. Border is px∈{0,TILE_W−1} or py∈{0,TILE_H−1}.
  4. rom_data==KEY → BG.
  5. Otherwise → rom_data.

## Timing
- Stage A (cycle N+1): geometry, active-hand lookup, `rom_addr` registered, flags registered.
- `rom_data` is valid at N+1+ROM_LAT. Flags travel through a ROM_LAT-deep delay line.
- `pixel` and `pixel_valid` are registered at N+2+ROM_LAT. Total latency = ROM_LAT+2 from the `h_cnt`/`v_cnt`/`valid` sample.
- Reset values:
  - `rom_addr`=0, `pixel`=0, `pixel_valid`=0.
  - All shadow and active present bits = 0.
  - `sel_q` = none; blink counter and phase = 0 (phase off).
  - Delay line cleared.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous). The row stays blank until a fresh load followed by a frame start.

## Structure
- Shared package: colour constants (KEY, BG, HL) and a slot-entry typedef {present, card[CARD_W]}.
- One sub-module, `card_hand_buffer`: shadow/active register file, frame-start swap, clear/write arbitration, `sel_q` latch.
- Top level: geometry counters, address generation, delay line, pixel mux.

## Test plan
- Write slot 2 with card 5, present; frame start. At h_cnt=64+3, v_cnt=7: rom_addr=5·1472+7·32+3=7587, exactly 1 cycle later. pixel=rom_data ROM_LAT+2 cycles after the sample.
- ROM model returns F0F at a pixel inside a present slot → pixel=BG. Empty slot 4 → BG for all of h_cnt 128..159.
- Write slot 1 mid-frame → the current frame still shows the old card, and the new card appears from the next frame start. `clr_hand` and a write to slot 3 in the same cycle → only slot 3 is present after the swap.
- sel_slot=0, BLINK=2 → the border of slot 0 is HL in frames 2–3, the sprite shows in frames 0–1 and 4–5, and the interior of slot 0 is never HL. sel_slot=15 → no HL anywhere.
- Sweep ROM_LAT 1..3 → `pixel_valid` edges trail `valid` edges by exactly ROM_LAT+2 cycles.
- Assert `rst` low mid-line → `pixel`, `pixel_valid` and `rom_addr` read 0 in the same cycle. After release, all slots show BG until a load followed by a frame start.
